// File: rtl/ml_min_search_pkg.sv
// Shared detector constants and helpers for the ML minimum-distance search.
// Candidate generator, detector and search block all take their sizes from here.
package ml_min_search_pkg;

  localparam int FIXED_POINT_WIDTH = 16;
  localparam int FRACTION_BITS     = 8;
  localparam int ML_NUM_RX         = 2;
  localparam int ML_NUM_CAND       = 16;

  // One guard bit beyond the worst-case sum of NUM_RX clipped samples.
  function automatic int acc_width(input int width, input int num_rx);
    return width + $clog2(num_rx) + 1;
  endfunction

endpackage

// File: rtl/ml_min_search_if.sv
// Sample-in / result-out handshake bundle of the minimum-distance search.
// master is the surrounding datapath, slave is the search block.
interface ml_min_search_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4,
  parameter int ACC_W = 18
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_metric;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [ACC_W-1:0] out_metric;
  logic             busy;

  modport master (
    output in_valid, in_metric, out_ready,
    input  in_ready, out_valid, out_index, out_metric, busy
  );

  modport slave (
    input  in_valid, in_metric, out_ready,
    output in_ready, out_valid, out_index, out_metric, busy
  );

endinterface

// File: rtl/ml_min_search_sat_accumulate.sv
// Combinational saturating adder: acc + sanitised sample, clipped at all-ones.
// Negative samples flag an upstream overflow and are clamped to the largest positive value.
module sat_accumulate #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [WIDTH-1:0] sample,
  output logic [ACC_W-1:0] sum
);

  logic [WIDTH-1:0] clipped;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W:0]   raw;

  always_comb begin
    clipped    = sample[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : sample;
    sample_ext = ACC_W'(clipped);
    raw        = {1'b0, acc} + {1'b0, sample_ext};
    sum        = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
  end

endmodule

// File: rtl/ml_min_search.sv
// Streaming minimum Euclidean distance search over NUM_CAND candidates of NUM_RX samples.
//   state   | meaning
//   COLLECT | accepting samples, accumulating distances, tracking the best candidate
//   DONE    | result presented, input stalled until the result handshake
module ml_min_search
  import ml_min_search_pkg::*;
#(
  parameter int WIDTH    = FIXED_POINT_WIDTH,
  parameter int NUM_RX   = ML_NUM_RX,
  parameter int NUM_CAND = ML_NUM_CAND,
  parameter int IDX_W    = $clog2(NUM_CAND),
  parameter int ACC_W    = acc_width(WIDTH, NUM_RX)
) (
  input logic            clk,
  input logic            rst,
  ml_min_search_if.slave bus
);

  localparam int RX_W = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_DONE    = 1'b1;

  typedef enum logic {
    COLLECT = ST_COLLECT,
    DONE    = ST_DONE
  } state_t;

  state_t           state;
  logic [RX_W-1:0]  rx_cnt;
  logic [IDX_W-1:0] cand_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] best;
  logic [IDX_W-1:0] best_idx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_index_q;
  logic [ACC_W-1:0] out_metric_q;
  logic             busy_q;

  logic [ACC_W-1:0] sum;
  logic             accept;
  logic             cand_done;
  logic             last_cand;
  logic             take;
  logic [ACC_W-1:0] next_best;
  logic [IDX_W-1:0] next_idx;

  sat_accumulate #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_sat_accumulate (
    .acc   (acc),
    .sample(bus.in_metric),
    .sum   (sum)
  );

  // Candidate 0 always seeds the best; strict less-than keeps the lowest index on ties.
  always_comb begin
    accept    = bus.in_valid && in_ready_q;
    cand_done = (rx_cnt == RX_W'(NUM_RX - 1));
    last_cand = (cand_cnt == IDX_W'(NUM_CAND - 1));
    take      = (cand_cnt == '0) || (sum < best);
    next_best = take ? sum : best;
    next_idx  = take ? cand_cnt : best_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      rx_cnt       <= '0;
      cand_cnt     <= '0;
      acc          <= '0;
      best         <= '1;
      best_idx     <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_metric_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (!cand_done) begin
              acc    <= sum;
              rx_cnt <= rx_cnt + 1'b1;
            end else begin
              acc      <= '0;
              rx_cnt   <= '0;
              best     <= next_best;
              best_idx <= next_idx;
              if (last_cand) begin
                cand_cnt     <= '0;
                state        <= DONE;
                in_ready_q   <= 1'b0;
                out_valid_q  <= 1'b1;
                out_index_q  <= next_idx;
                out_metric_q <= next_best;
              end else begin
                cand_cnt <= cand_cnt + 1'b1;
              end
            end
          end
        end
        DONE: begin
          // in_ready only reopens after the handshake edge, so no sample lands in that cycle.
          if (bus.out_ready) begin
            state       <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_metric = out_metric_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ml_min_search.sv
// Directed bench for ml_min_search: basic, tie, overflow clamp, backpressure, bubbles, mid-search reset.
module tb_ml_min_search;

  localparam int W    = 16;
  localparam int NRX  = 2;
  localparam int NC   = 4;
  localparam int IW   = 2;
  localparam int AW   = 18;
  localparam int NRXB = 4;
  localparam int NCB  = 2;
  localparam int IWB  = 1;
  localparam int AWB  = 19;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ml_min_search_if #(.WIDTH(W), .IDX_W(IW),  .ACC_W(AW))  bus_a ();
  ml_min_search_if #(.WIDTH(W), .IDX_W(IWB), .ACC_W(AWB)) bus_b ();

  ml_min_search #(.WIDTH(W), .NUM_RX(NRX), .NUM_CAND(NC), .IDX_W(IW), .ACC_W(AW)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  ml_min_search #(.WIDTH(W), .NUM_RX(NRXB), .NUM_CAND(NCB), .IDX_W(IWB), .ACC_W(AWB)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus_a.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Beats first..last of v, optional random gaps; hold keeps in_valid high afterwards.
  task automatic send_beats(input logic [7:0][15:0] v, input int first, input int last,
                            input int max_gap, input bit hold);
    for (int i = first; i <= last; i++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(negedge clk);
        bus_a.in_valid = 1'b0;
      end
      @(negedge clk);
      bus_a.in_valid  = 1'b1;
      bus_a.in_metric = v[i];
      wait_ready();
      check("no_early_valid", 32'(bus_a.out_valid), 32'd0);
    end
    @(negedge clk);
    if (hold) bus_a.in_metric = 16'd999;
    else bus_a.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int idx, input int metric);
    check({tag, "_valid"},  32'(bus_a.out_valid),  32'd1);
    check({tag, "_index"},  32'(bus_a.out_index),  32'(idx));
    check({tag, "_metric"}, 32'(bus_a.out_metric), 32'(metric));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus_a.in_ready),   32'd1);
    check({tag, "_out_valid"}, 32'(bus_a.out_valid),  32'd0);
    check({tag, "_out_index"}, 32'(bus_a.out_index),  32'd0);
    check({tag, "_out_metric"}, 32'(bus_a.out_metric), 32'd0);
    check({tag, "_busy"},      32'(bus_a.busy),       32'd0);
  endtask

  logic [7:0][15:0] basic_v, tie_v, ovf_v, bp_v, abort_v;

  initial begin
    // Element [0] is the first beat; pairs form one candidate each.
    basic_v = {16'd20, 16'd1, 16'd8, 16'd8, 16'd4, 16'd3, 16'd5, 16'd10};
    tie_v   = {16'd9, 16'd9, 16'd0, 16'd4, 16'd3, 16'd1, 16'd2, 16'd2};
    ovf_v   = {16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd0, 16'h8000};
    bp_v    = {16'd3, 16'd0, 16'd30, 16'd30, 16'd2, 16'd2, 16'd1, 16'd50};
    abort_v = {16'd0, 16'd0, 16'd0, 16'd100, 16'd0, 16'd0, 16'd0, 16'd0};

    rst             = 1'b1;
    bus_a.in_valid  = 1'b0;
    bus_a.in_metric = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.in_metric = '0;
    bus_b.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    send_beats(basic_v, 0, 7, 0, 1'b0);
    expect_result("basic", 1, 7);
    check("basic_busy", 32'(bus_a.busy), 32'd1);
    @(negedge clk);
    check("basic_pulse", 32'(bus_a.out_valid), 32'd0);
    check("basic_busy_fall", 32'(bus_a.busy), 32'd0);
    check("basic_ready_back", 32'(bus_a.in_ready), 32'd1);

    send_beats(tie_v, 0, 7, 0, 1'b0);
    expect_result("tie", 0, 4);
    @(negedge clk);

    send_beats(ovf_v, 0, 7, 0, 1'b0);
    expect_result("overflow", 1, 200);
    @(negedge clk);

    bus_a.out_ready = 1'b0;
    send_beats(bp_v, 0, 7, 0, 1'b1);
    expect_result("bp", 3, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
      expect_result("bp_hold", 3, 3);
    end
    bus_a.out_ready = 1'b1;
    bus_a.in_metric = basic_v[0];
    check("bp_handshake_ready", 32'(bus_a.in_ready), 32'd0);
    @(negedge clk);
    check("bp_after_valid", 32'(bus_a.out_valid), 32'd0);
    check("bp_after_ready", 32'(bus_a.in_ready), 32'd1);
    check("bp_after_busy", 32'(bus_a.busy), 32'd0);
    send_beats(basic_v, 1, 7, 0, 1'b0);
    expect_result("bp_next", 1, 7);
    @(negedge clk);

    send_beats(basic_v, 0, 7, 5, 1'b0);
    expect_result("bubbles", 1, 7);
    @(negedge clk);

    send_beats(abort_v, 0, 4, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    send_beats(tie_v, 0, 7, 0, 1'b0);
    expect_result("after_rst", 0, 4);
    @(negedge clk);

    for (int i = 0; i < NRXB * NCB; i++) begin
      @(negedge clk);
      check("b_in_ready", 32'(bus_b.in_ready), 32'd1);
      bus_b.in_valid  = 1'b1;
      bus_b.in_metric = 16'h7FFF;
    end
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    check("rx4_valid",  32'(bus_b.out_valid),  32'd1);
    check("rx4_index",  32'(bus_b.out_index),  32'd0);
    check("rx4_metric", 32'(bus_b.out_metric), 32'd131068);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
